// File: rtl/ml_host_tx_pkg.sv
// Shared definitions for the ML nibble-link host transmitter: state encoding,
// link output bundle with its reset values, and nibble-order helper.
package ml_host_tx_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CS_SU,
    ST_HI_CLK,
    ST_LO_SU,
    ST_LO_CLK,
    ST_HI_SU,
    ST_WAIT,
    ST_CS_HOLD,
    ST_GAP
  } state_e;

  typedef struct packed {
    logic       csb;
    logic       clk;
    logic [3:0] io_do;
    logic [3:0] io_oe;
    logic       busy;
  } link_out_t;

  localparam link_out_t LINK_RST = '{csb: 1'b1, clk: 1'b0, io_do: 4'h0, io_oe: 4'h0, busy: 1'b0};

  // High nibble travels first on the link.
  function automatic logic [3:0] pick_nibble(input logic [7:0] b, input logic hi);
    return hi ? b[7:4] : b[3:0];
  endfunction

endpackage

// File: rtl/ml_host_tx.sv
// Host-side ML nibble-link transmitter: frames a byte stream as csb-low transfers,
// high nibble captured on ml_clk rise, low nibble on ml_clk fall.
module ml_host_tx
  import ml_host_tx_pkg::*;
#(
  parameter int DIV    = 4,
  parameter int CS_GAP = 4
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       in_ready,
  output logic       busy,
  output logic       ml_csb,
  output logic       ml_clk,
  output logic [3:0] ml_io_do,
  output logic [3:0] ml_io_oe
);

  localparam logic [CNT_W-1:0] SEG_RELOAD = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] GAP_RELOAD = CNT_W'(CS_GAP - 1);

  state_e           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_seg_cnt, w_seg_cnt_nxt;
  logic             r_hold_2nd, w_hold_2nd_nxt;
  logic [7:0]       r_byte, w_byte_nxt;
  logic             r_last;
  link_out_t        r_out, w_out_nxt;
  logic             w_seg_done;
  logic             w_accept;

  assign w_seg_done = (r_seg_cnt == '0);

  // NOTE: in_ready is gated by resetn directly so nothing is accepted on a reset edge.
  always_comb begin
    in_ready = 1'b0;
    if (resetn) begin
      case (r_state)
        ST_IDLE, ST_WAIT: in_ready = 1'b1;
        ST_LO_CLK:        in_ready = w_seg_done && !r_last;
        default:          in_ready = 1'b0;
      endcase
    end
  end

  assign w_accept   = in_valid && in_ready;
  assign w_byte_nxt = w_accept ? in_data : r_byte;

  // State register. NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state    <= ST_IDLE;
      r_seg_cnt  <= '0;
      r_hold_2nd <= 1'b0;
      r_byte     <= 8'h00;
      r_last     <= 1'b0;
      r_out      <= LINK_RST;
    end else begin
      r_state    <= w_state_nxt;
      r_seg_cnt  <= w_seg_cnt_nxt;
      r_hold_2nd <= w_hold_2nd_nxt;
      r_out      <= w_out_nxt;
      if (w_accept) begin
        r_byte <= in_data;
        r_last <= in_last;
      end
    end
  end

  // Next-state and segment timer. NOTE: every comb output gets a default first (no latches).
  always_comb begin
    w_state_nxt    = r_state;
    w_seg_cnt_nxt  = w_seg_done ? '0 : r_seg_cnt - 1'b1;
    w_hold_2nd_nxt = r_hold_2nd;
    case (r_state)
      ST_IDLE: if (w_accept) begin
        w_state_nxt   = ST_CS_SU;
        w_seg_cnt_nxt = SEG_RELOAD;
      end
      ST_CS_SU, ST_HI_SU: if (w_seg_done) begin
        w_state_nxt   = ST_HI_CLK;
        w_seg_cnt_nxt = SEG_RELOAD;
      end
      ST_HI_CLK: if (w_seg_done) begin
        w_state_nxt   = ST_LO_SU;
        w_seg_cnt_nxt = SEG_RELOAD;
      end
      ST_LO_SU: if (w_seg_done) begin
        w_state_nxt   = ST_LO_CLK;
        w_seg_cnt_nxt = SEG_RELOAD;
      end
      ST_LO_CLK: if (w_seg_done) begin
        if (r_last) begin
          w_state_nxt    = ST_CS_HOLD;
          w_seg_cnt_nxt  = SEG_RELOAD;
          w_hold_2nd_nxt = 1'b0;
        end else if (w_accept) begin
          w_state_nxt   = ST_HI_SU;
          w_seg_cnt_nxt = SEG_RELOAD;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: if (w_accept) begin
        w_state_nxt   = ST_HI_SU;
        w_seg_cnt_nxt = SEG_RELOAD;
      end
      // Hold csb low for two segments so the final fall is well inside the frame.
      ST_CS_HOLD: if (w_seg_done) begin
        w_seg_cnt_nxt = SEG_RELOAD;
        if (!r_hold_2nd) begin
          w_hold_2nd_nxt = 1'b1;
        end else begin
          w_state_nxt   = ST_GAP;
          w_seg_cnt_nxt = GAP_RELOAD;
        end
      end
      ST_GAP: if (w_seg_done) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Link outputs decoded from the next state, then registered with it.
  always_comb begin
    w_out_nxt = LINK_RST;
    case (w_state_nxt)
      ST_CS_SU, ST_HI_SU: begin
        w_out_nxt.csb   = 1'b0;
        w_out_nxt.io_do = pick_nibble(w_byte_nxt, 1'b1);
        w_out_nxt.io_oe = 4'hF;
        w_out_nxt.busy  = 1'b1;
      end
      ST_HI_CLK: begin
        w_out_nxt.csb   = 1'b0;
        w_out_nxt.clk   = 1'b1;
        w_out_nxt.io_do = pick_nibble(w_byte_nxt, 1'b1);
        w_out_nxt.io_oe = 4'hF;
        w_out_nxt.busy  = 1'b1;
      end
      ST_LO_SU: begin
        w_out_nxt.csb   = 1'b0;
        w_out_nxt.clk   = 1'b1;
        w_out_nxt.io_do = pick_nibble(w_byte_nxt, 1'b0);
        w_out_nxt.io_oe = 4'hF;
        w_out_nxt.busy  = 1'b1;
      end
      ST_LO_CLK, ST_WAIT, ST_CS_HOLD: begin
        w_out_nxt.csb   = 1'b0;
        w_out_nxt.io_do = pick_nibble(w_byte_nxt, 1'b0);
        w_out_nxt.io_oe = 4'hF;
        w_out_nxt.busy  = 1'b1;
      end
      ST_GAP:  w_out_nxt.busy = 1'b1;
      default: w_out_nxt = LINK_RST;
    endcase
  end

  assign busy     = r_out.busy;
  assign ml_csb   = r_out.csb;
  assign ml_clk   = r_out.clk;
  assign ml_io_do = r_out.io_do;
  assign ml_io_oe = r_out.io_oe;

endmodule
